// File: rtl/instr_seq_ctrl.sv
// Multi-cycle RV32I control sequencer: fetch, decode, execute, optional memory
// access and writeback, with retire counting and halt on illegal/system/timeout.
module instr_seq_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  output logic             imemReq,
  input  logic             imemAck,
  input  logic [31:0]      imemData,
  output logic [31:0]      instr,
  output logic             dmemReq,
  output logic             dmemWe,
  input  logic             dmemAck,
  input  logic             brTaken,
  output logic             aluSrcImm,
  output logic [1:0]       wbSel,
  output logic [1:0]       pcSel,
  output logic             regWe,
  output logic             pcWe,
  output logic [CNT_W-1:0] retired,
  output logic             halted,
  output logic             illegal,
  output logic             busErr
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC,
    C_SYSTEM, C_BAD
  } class_t;

  state_t            state;
  class_t            cls;
  class_t            op_class;
  logic [WAIT_W-1:0] wait_cnt;

  function automatic class_t classify(input logic [6:0] op);
    case (op)
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b1100011: return C_BRANCH;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      7'b0110111: return C_LUI;
      7'b0010111: return C_AUIPC;
      7'b1110011: return C_SYSTEM;
      default:    return C_BAD;
    endcase
  endfunction

  assign op_class = classify(instr[6:0]);

  // The wait counter runs only while a request is outstanding; the last
  // allowed cycle still accepts an ack before declaring a bus error.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= S_IDLE;
      cls      <= C_R;
      instr    <= '0;
      retired  <= '0;
      wait_cnt <= '0;
      halted   <= 1'b0;
      illegal  <= 1'b0;
      busErr   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
          end
        end
        S_FETCH: begin
          if (imemAck) begin
            instr <= imemData;
            state <= S_DECODE;
          end else if (wait_cnt == WAIT_LAST) begin
            state  <= S_HALT;
            halted <= 1'b1;
            busErr <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          cls <= op_class;
          case (op_class)
            C_SYSTEM: begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
            C_BAD: begin
              state   <= S_HALT;
              halted  <= 1'b1;
              illegal <= 1'b1;
            end
            default: state <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          if (cls == C_BRANCH) begin
            retired  <= retired + CNT_W'(1);
            state    <= S_FETCH;
            wait_cnt <= '0;
          end else if (cls == C_LOAD || cls == C_STORE) begin
            state    <= S_MEM;
            wait_cnt <= '0;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (dmemAck) begin
            if (cls == C_STORE) begin
              retired  <= retired + CNT_W'(1);
              state    <= S_FETCH;
              wait_cnt <= '0;
            end else begin
              state <= S_WB;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            state  <= S_HALT;
            halted <= 1'b1;
            busErr <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WB: begin
          retired  <= retired + CNT_W'(1);
          state    <= S_FETCH;
          wait_cnt <= '0;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes and selects are a pure decode of the registered state and class;
  // only the store-completion PC write looks at the same-cycle ack.
  always_comb begin
    imemReq   = (state == S_FETCH);
    dmemReq   = (state == S_MEM);
    dmemWe    = (state == S_MEM) && (cls == C_STORE);
    aluSrcImm = 1'b0;
    wbSel     = 2'd0;
    pcSel     = 2'd0;
    regWe     = 1'b0;
    pcWe      = 1'b0;
    if (state == S_EXEC || state == S_MEM || state == S_WB)
      aluSrcImm = (cls != C_R) && (cls != C_BRANCH);
    case (state)
      S_EXEC: begin
        if (cls == C_BRANCH) begin
          pcWe  = 1'b1;
          pcSel = brTaken ? 2'd1 : 2'd0;
        end
      end
      S_MEM: pcWe = (cls == C_STORE) && dmemAck;
      S_WB: begin
        pcWe  = 1'b1;
        regWe = (instr[11:7] != 5'd0);
        case (cls)
          C_LOAD: wbSel = 2'd1;
          C_JAL: begin
            wbSel = 2'd2;
            pcSel = 2'd1;
          end
          C_JALR: begin
            wbSel = 2'd2;
            pcSel = 2'd2;
          end
          C_LUI:   wbSel = 2'd3;
          default: wbSel = 2'd0;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Scoreboard bench for instr_seq_ctrl: a per-instruction reference model pushes
// expected outcomes, and a monitor checks them when PC writes or halts appear.
module tb_instr_seq_ctrl;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 16;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic             clk = 1'b0;
  logic             rstN = 1'b1;
  logic             start = 1'b0;
  logic             imemReq;
  logic             imemAck = 1'b0;
  logic [31:0]      imemData = '0;
  logic [31:0]      instr;
  logic             dmemReq;
  logic             dmemWe;
  logic             dmemAck = 1'b0;
  logic             brTaken = 1'b0;
  logic             aluSrcImm;
  logic [1:0]       wbSel;
  logic [1:0]       pcSel;
  logic             regWe;
  logic             pcWe;
  logic [CNT_W-1:0] retired;
  logic             halted;
  logic             illegal;
  logic             busErr;

  always #5 clk = ~clk;

  instr_seq_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstN(rstN), .start(start),
    .imemReq(imemReq), .imemAck(imemAck), .imemData(imemData), .instr(instr),
    .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAck(dmemAck), .brTaken(brTaken),
    .aluSrcImm(aluSrcImm), .wbSel(wbSel), .pcSel(pcSel), .regWe(regWe),
    .pcWe(pcWe), .retired(retired), .halted(halted), .illegal(illegal),
    .busErr(busErr)
  );

  typedef struct {
    bit               is_halt;
    logic [31:0]      word;
    int               cycles;
    logic             reg_we;
    logic [1:0]       wb_sel;
    logic [1:0]       pc_sel;
    logic             alu_imm;
    int               dmem_cycles;
    logic             dmem_we;
    logic [CNT_W-1:0] ret;
    logic             ill;
    logic             berr;
  } exp_t;

  exp_t             sb[$];
  int               tests = 0;
  int               fails = 0;
  logic [CNT_W-1:0] model_ret = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t blankExp();
    exp_t e;
    e.is_halt = 0; e.word = '0; e.cycles = 0; e.reg_we = 0; e.wb_sel = 0;
    e.pc_sel = 0; e.alu_imm = 1; e.dmem_cycles = 0; e.dmem_we = 0;
    e.ret = model_ret; e.ill = 0; e.berr = 0;
    return e;
  endfunction

  // Reference: base latency, writeback source and next-PC source per class.
  function automatic exp_t model(input logic [31:0] w, input bit br, input int d_f, input int d_m);
    exp_t e = blankExp();
    bit   has_rd = (w[11:7] != 5'd0);
    e.word = w;
    case (w[6:0])
      OP_R:      begin e.cycles = 4; e.reg_we = has_rd; e.alu_imm = 0; end
      OP_I:      begin e.cycles = 4; e.reg_we = has_rd; end
      OP_AUIPC:  begin e.cycles = 4; e.reg_we = has_rd; end
      OP_LUI:    begin e.cycles = 4; e.reg_we = has_rd; e.wb_sel = 3; end
      OP_JAL:    begin e.cycles = 4; e.reg_we = has_rd; e.wb_sel = 2; e.pc_sel = 1; end
      OP_JALR:   begin e.cycles = 4; e.reg_we = has_rd; e.wb_sel = 2; e.pc_sel = 2; end
      OP_LOAD:   begin e.cycles = 5 + d_m; e.reg_we = has_rd; e.wb_sel = 1; e.dmem_cycles = d_m + 1; end
      OP_STORE:  begin e.cycles = 4 + d_m; e.dmem_cycles = d_m + 1; e.dmem_we = 1; end
      OP_BRANCH: begin e.cycles = 3; e.alu_imm = 0; e.pc_sel = br ? 2'd1 : 2'd0; end
      default:   e.cycles = 0;
    endcase
    e.cycles += d_f;
    return e;
  endfunction

  function automatic exp_t haltExp(input bit ill, input bit berr, input int cycles);
    exp_t e = blankExp();
    e.is_halt = 1; e.ill = ill; e.berr = berr; e.cycles = cycles;
    return e;
  endfunction

  function automatic logic [31:0] randInstr();
    logic [6:0]  ops[9];
    logic [31:0] w;
    ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    w = $urandom;
    w[6:0] = ops[$urandom_range(0, 8)];
    if ($urandom_range(0, 3) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  task automatic waitSig(input int which, input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      if ((which == 0 && imemReq) || (which == 1 && dmemReq) || (which == 2 && halted)) begin
        ok = 1;
        return;
      end
      @(posedge clk); #1;
    end
    tests++;
    fails++;
    $display("[TB] FAIL wait_%0d: signal still 0 after %0d cycles, expected 1", which, limit);
  endtask

  task automatic applyReset();
    @(posedge clk); #1;
    start = 0; imemAck = 0; dmemAck = 0; brTaken = 0; imemData = '0;
    rstN = 0;
    #1;
    checkOutput("reset_strobes", {imemReq, dmemReq, dmemWe, aluSrcImm, wbSel, pcSel,
                                  regWe, pcWe, halted, illegal, busErr}, 0);
    checkOutput("reset_instr", instr, 0);
    checkOutput("reset_retired", 32'(retired), 0);
    sb.delete();
    model_ret = '0;
    repeat (2) @(negedge clk);
    rstN = 1;
    @(posedge clk); #1;
  endtask

  task automatic pulseStart();
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  // d_m < 0 leaves the data access unacknowledged.
  task automatic applyStimulus(input logic [31:0] w, input bit br, input int d_f,
                               input int d_m, input bit push, input bit noise);
    bit ok;
    if (push) begin
      sb.push_back(model(w, br, d_f, d_m));
      model_ret++;
    end
    waitSig(0, 40, ok);
    if (!ok) return;
    repeat (d_f) begin @(posedge clk); #1; end
    imemAck = 1; imemData = w;
    @(posedge clk); #1;
    imemAck = 0; imemData = $urandom;
    brTaken = br;
    if (noise) begin
      dmemAck = 1;
      @(posedge clk); #1;
      dmemAck = 0;
    end
    if (w[6:0] == OP_LOAD || w[6:0] == OP_STORE) begin
      waitSig(1, 10, ok);
      if (!ok || d_m < 0) return;
      repeat (d_m) begin @(posedge clk); #1; end
      dmemAck = 1;
      @(posedge clk); #1;
      dmemAck = 0;
    end
  endtask

  task automatic drain();
    bit ok;
    waitSig(0, 40, ok);
    checkOutput("queue_drained", sb.size(), 0);
    checkOutput("retired_total", 32'(retired), 32'(model_ret));
  endtask

  task automatic finishHalt();
    bit ok;
    waitSig(2, 2 * TIMEOUT + 10, ok);
    @(negedge clk);
    @(posedge clk); #1;
    checkOutput("halt_queue_drained", sb.size(), 0);
  endtask

  // Monitor: pops one expectation per PC write or per halt entry.
  initial begin : monitor
    bit   busy;
    bit   prev_halt;
    int   cnt;
    int   dcnt;
    int   stray;
    logic dwe;
    exp_t e;
    busy = 0; prev_halt = 0; cnt = 0; dcnt = 0; stray = 0; dwe = 0;
    forever begin
      @(negedge clk);
      if (!rstN) begin
        busy = 0; prev_halt = 0;
        continue;
      end
      if (imemReq && !busy) begin
        busy = 1; cnt = 0; dcnt = 0; stray = 0; dwe = 0;
      end
      if (busy) cnt++;
      if (dmemReq) begin
        dcnt++;
        dwe = dmemWe;
      end
      if (regWe && !pcWe) stray++;
      if (pcWe) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_pcWe", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("kind_retire", 32'(e.is_halt), 0);
          checkOutput("latency", cnt, e.cycles);
          checkOutput("instr", instr, e.word);
          checkOutput("regWe", 32'(regWe), 32'(e.reg_we));
          checkOutput("wbSel", 32'(wbSel), 32'(e.wb_sel));
          checkOutput("pcSel", 32'(pcSel), 32'(e.pc_sel));
          checkOutput("aluSrcImm", 32'(aluSrcImm), 32'(e.alu_imm));
          checkOutput("retired_before", 32'(retired), 32'(e.ret));
          checkOutput("dmem_cycles", dcnt, e.dmem_cycles);
          if (e.dmem_cycles > 0) checkOutput("dmemWe", 32'(dwe), 32'(e.dmem_we));
          checkOutput("stray_regWe", stray, 0);
        end
        busy = 0;
      end
      if (halted && !prev_halt) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_halt", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("kind_halt", 32'(e.is_halt), 1);
          checkOutput("halt_latency", cnt, e.cycles);
          checkOutput("illegal", 32'(illegal), 32'(e.ill));
          checkOutput("busErr", 32'(busErr), 32'(e.berr));
          checkOutput("halt_retired", 32'(retired), 32'(e.ret));
          checkOutput("halt_reqs", {imemReq, dmemReq, pcWe, regWe}, 0);
        end
        busy = 0;
      end
      prev_halt = halted;
    end
  end

  initial begin : stimulus
    logic [31:0] w;
    applyReset();
    pulseStart();
    applyStimulus(32'h00500093, 0, 0, 0, 1, 0);
    applyStimulus(32'h0000A103, 0, 0, 3, 1, 0);
    applyStimulus(32'h00208463, 1, 0, 0, 1, 0);
    applyStimulus(32'h00208463, 0, 0, 0, 1, 0);
    applyStimulus(32'h0080006F, 0, 0, 0, 1, 0);
    applyStimulus(32'h00112023, 0, 1, 2, 1, 1);
    for (int i = 0; i < 40; i++) begin
      w = randInstr();
      applyStimulus(w, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                    int'($urandom_range(0, 3)), 1, ($urandom_range(0, 3) == 0));
    end
    drain();

    // Illegal opcode, then start must not revive the halted sequencer.
    applyReset();
    pulseStart();
    sb.push_back(haltExp(1, 0, 3));
    applyStimulus(32'hFFFFFFFF, 0, 0, 0, 0, 0);
    finishHalt();
    pulseStart();
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("start_ignored", {halted, illegal, imemReq}, 3'b110);

    applyReset();
    pulseStart();
    sb.push_back(haltExp(0, 0, 4));
    applyStimulus(32'h00000073, 0, 1, 0, 0, 0);
    finishHalt();

    // Fetch ack withheld: halt after TIMEOUT request cycles.
    applyReset();
    pulseStart();
    sb.push_back(haltExp(0, 1, TIMEOUT + 1));
    finishHalt();

    // Ack on the last allowed fetch cycle still proceeds.
    applyReset();
    pulseStart();
    applyStimulus(32'h00500093, 0, TIMEOUT - 1, 0, 1, 0);
    drain();

    // Data ack withheld: bus error from MEM.
    applyReset();
    pulseStart();
    sb.push_back(haltExp(0, 1, 3 + TIMEOUT + 1));
    applyStimulus(32'h0000A103, 0, 0, -1, 0, 0);
    finishHalt();

    // Reset in the middle of a store access aborts it cleanly.
    applyReset();
    pulseStart();
    applyStimulus(32'h00112023, 0, 0, -1, 0, 0);
    applyReset();
    for (int i = 0; i < 3; i++) begin
      checkOutput("post_abort_idle", {imemReq, dmemReq, regWe, pcWe, halted}, 0);
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/instr_seq_ctrl.md
# instr_seq_ctrl

Multi-cycle control sequencer for the RV32I instruction processing path. Fetches an instruction over a request/acknowledge port, latches it, and steps it through DECODE, EXEC, optional MEM and WB. It emits one-cycle strobes for the register file, the PC and data memory, plus the datapath steering selects. It also counts retired instructions and halts on illegal opcodes, system instructions or memory timeouts.

## Interface
- CNT_W, 32, width of retired-instruction counter
- TIMEOUT, 255, max cycles spent waiting for an ack in FETCH or MEM before a bus error
- clk  in  1  single clock, rising edge
- rstN  in  1  asynchronous, active-low reset
- start  in  1  leave IDLE; ignored in all other states
- imemReq  out  1  instruction fetch request
- imemAck  in  1  fetch accepted, imemData valid this cycle
- imemData  in  32  fetched instruction word
- instr  out  32  latched instruction register (feeds imm gen/decoder)
- dmemReq  out  1  data memory request
- dmemWe  out  1  store qualifier, valid with dmemReq
- dmemAck  in  1  data access complete
- brTaken  in  1  branch compare result from ALU, sampled in EXEC
- aluSrcImm  out  1  ALU operand B = immediate
- wbSel  out  2  0 ALU, 1 load data, 2 PC+4, 3 immediate
- pcSel  out  2  0 PC+4, 1 PC+imm, 2 ALU result (jalr)
- regWe  out  1  register write strobe
- pcWe  out  1  PC update strobe
- retired  out  CNT_W  retired-instruction count
- halted  out  1  sequencer stopped
- illegal  out  1  halt cause: unknown opcode
- busErr  out  1  halt cause: ack timeout

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: start=1 -> FETCH.
- FETCH: imemReq=1. On imemAck, latch instr<=imemData and go to DECODE.
- DECODE: one cycle. Classify instr[6:0] as R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111, SYSTEM 1110011.
  - SYSTEM -> HALT with no flag.
  - Any other opcode -> HALT with illegal=1.
  - All other classes -> EXEC.
- EXEC: one cycle. aluSrcImm=1 for all classes except R and BRANCH.
  - BRANCH: pcWe=1, pcSel=brTaken?1:0, retire, then -> FETCH.
  - LOAD/STORE -> MEM.
  - Others -> WB.
- MEM: dmemReq=1, dmemWe=1 for STORE only. Wait for dmemAck.
  - STORE: pcWe=1, pcSel=0, retire, -> FETCH (all in the ack cycle).
  - LOAD: -> WB.
- WB: regWe=1 unless instr[11:7]==0. wbSel and pcSel by class:
  - LOAD: wbSel 1.
  - JAL: wbSel 2, pcSel 1.
  - JALR: wbSel 2, pcSel 2.
  - LUI: wbSel 3.
  - R/I/AUIPC: wbSel 0.
  - pcSel is 0 when not listed. pcWe=1, retire, -> FETCH.
- HALT: sticky until reset. halted=1. Cause flags hold their value.
- "Retire" means retired<=retired+1. It wraps modulo 2^CNT_W.
- Wait counter: cleared on entry to FETCH or MEM, incremented each cycle without ack. If it reaches TIMEOUT with no ack -> HALT, busErr=1, no retire, no strobes. An ack arriving in the same cycle the counter reaches TIMEOUT wins.
- Strobes (regWe, pcWe, dmemReq, imemReq) are decoded from state and latched class only. They never depend on the ack in the same cycle, except that the STORE-completion pcWe is qualified by dmemAck.

## Timing
- Reset (rstN=0, asynchronous): state IDLE, instr=0, retired=0, wait counter=0, halted/illegal/busErr=0. All strobes and selects are 0.
- Reset asserted mid-instruction aborts it. No partial strobes are issued after release.
- Zero-wait memory latencies, counted in cycles from FETCH entry to the next FETCH:
  - BRANCH: 3.
  - R/I/LUI/AUIPC/JAL/JALR: 4.
  - STORE: 4.
  - LOAD: 5.
- Each wait cycle without ack adds one cycle.
- imemReq and dmemReq stay asserted continuously until ack. Ack without a request is ignored.
- instr changes only on the cycle after a FETCH ack.
- Throughput: one instruction in flight at a time, no overlap.

## Test plan
- Reset, start, ADDI 0x00500093 with ack every cycle -> DECODE→EXEC→WB. regWe=1, wbSel=0, pcSel=0, aluSrcImm=1 in WB; retired=1 after 4 cycles.
- LW 0x0000A103 with dmemAck delayed 3 cycles -> dmemReq high 4 cycles, dmemWe=0; WB regWe=1, wbSel=1; total 8 cycles.
- BEQ with brTaken=1, then brTaken=0 -> EXEC pcWe=1 with pcSel=1, then 0; regWe never asserted; 3 cycles each.
- JAL with rd=x0 (0x0080006F) -> WB regWe=0, pcSel=1, pcWe=1, retired increments.
- Fetch of 0xFFFFFFFF -> HALT with illegal=1. Then ECALL 0x00000073 after reset -> HALT with illegal=0; start ignored afterwards.
- imemAck withheld for TIMEOUT cycles -> HALT, busErr=1. Rerun with ack exactly at cycle TIMEOUT -> normal DECODE. Also assert rstN low mid-MEM -> all outputs 0 immediately.
